// File: rtl/regbank_sb.sv
// regbank_sb: parametrised register bank with a per-register scoreboard and a
// sequenced bulk-clear engine. Decode/issue reads operands and reserves
// destinations; writeback writes results and releases them.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low; clears array, busy bits, clear engine
//   sr1, sr2         read addresses
//   rdData1/2        read data (combinational, with optional write bypass)
//   busy1/2          scoreboard state of sr1/sr2 (combinational)
//   write, dr,
//   wrData           write port; a write also releases the busy bit of dr
//   rsv, rsv_dr      reserve port; sets the busy bit of rsv_dr
//   clr_req          start a one-register-per-cycle clear of the whole bank
//   clr_busy         clear sweep in progress (write/rsv/clr_req ignored)
module regbank_sb #(
  parameter int WIDTH   = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    sr1,
  input  logic [AW-1:0]    sr2,
  output logic [WIDTH-1:0] rdData1,
  output logic [WIDTH-1:0] rdData2,
  output logic             busy1,
  output logic             busy2,
  input  logic             write,
  input  logic [AW-1:0]    dr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_dr,
  input  logic             clr_req,
  output logic             clr_busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_reg;
  logic [AW-1:0]   idx_reg;
  logic            clr_busy_reg;

  // Flattened views of the per-entry storage, used by the read ports.
  logic [WIDTH-1:0] regs_view [DEPTH];
  logic [DEPTH-1:0] busy_vec;

  // Qualified write/reserve: blocked during a sweep and, with a hardwired
  // zero register, dropped when aimed at r0.
  logic wr_ok;
  logic rsv_ok;

  assign wr_ok  = write && !clr_busy_reg && !((ZERO_R0 != 0) && (dr == '0));
  assign rsv_ok = rsv   && !clr_busy_reg && !((ZERO_R0 != 0) && (rsv_dr == '0));

  assign clr_busy = clr_busy_reg;

  // Clear engine. clr_busy is registered together with the state so it is
  // high for exactly DEPTH cycles; the last visited index returns to IDLE
  // without an extra wrap cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      clr_busy_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (clr_req) begin
        state_reg    <= SWEEP;
        idx_reg      <= '0;
        clr_busy_reg <= 1'b1;
      end
    end else begin
      if (idx_reg == {AW{1'b1}}) begin
        state_reg    <= IDLE;
        idx_reg      <= '0;
        clr_busy_reg <= 1'b0;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  // Storage: one register slice per entry. The whole bank must clear
  // asynchronously, so this is flop-based rather than a RAM.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;
      logic             busy_reg;
      logic             hit_clr;
      logic             hit_wr;
      logic             hit_rsv;

      assign hit_clr = clr_busy_reg && (idx_reg == AW'(gi));
      assign hit_wr  = wr_ok  && (dr     == AW'(gi));
      assign hit_rsv = rsv_ok && (rsv_dr == AW'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else if (hit_clr) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          if (hit_wr) begin
            data_reg <= wrData;
          end
          // A reserve in the same cycle as a write wins: the new producer
          // owns the register.
          if (hit_rsv) begin
            busy_reg <= 1'b1;
          end else if (hit_wr) begin
            busy_reg <= 1'b0;
          end
        end
      end

      assign regs_view[gi] = data_reg;
      assign busy_vec[gi]  = busy_reg;
    end
  endgenerate

  // Read ports: zero register first, then bypass of the accepted write,
  // otherwise the stored entry.
  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];
  logic             rd_busy [2];

  assign rd_addr[0] = sr1;
  assign rd_addr[1] = sr2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [WIDTH-1:0] data_c;
      logic             busy_c;

      always_comb begin
        data_c = regs_view[rd_addr[gi]];
        busy_c = busy_vec[rd_addr[gi]];
        if ((ZERO_R0 != 0) && (rd_addr[gi] == '0)) begin
          data_c = '0;
          busy_c = 1'b0;
        end else if ((BYPASS != 0) && wr_ok && (dr == rd_addr[gi])) begin
          data_c = wrData;
          busy_c = 1'b0;
        end
      end

      assign rd_data[gi] = data_c;
      assign rd_busy[gi] = busy_c;
    end
  endgenerate

  assign rdData1 = rd_data[0];
  assign rdData2 = rd_data[1];
  assign busy1   = rd_busy[0];
  assign busy2   = rd_busy[1];

endmodule

// File: tb/tb_regbank_sb.sv
// Scoreboard bench for regbank_sb: stimulus pushes hand-computed expected
// read-port state into a queue, a monitor on the falling edge pops and
// compares. A second instance with BYPASS=0 shares all inputs.
module tb_regbank_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  sr1, sr2, dr, rsv_dr;
  logic [31:0] wrData;
  logic        write, rsv, clr_req;
  logic [31:0] rdData1, rdData2;
  logic        busy1, busy2, clr_busy;
  logic [31:0] nb_rd1, nb_rd2;
  logic        nb_b1, nb_b2, nb_cb;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        cb;
    bit          chk_nb;
    logic [31:0] nb1;
  } exp_t;

  exp_t sb_q[$];

  regbank_sb #(.WIDTH(32), .AW(5), .ZERO_R0(1), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .sr1(sr1), .sr2(sr2),
    .rdData1(rdData1), .rdData2(rdData2), .busy1(busy1), .busy2(busy2),
    .write(write), .dr(dr), .wrData(wrData), .rsv(rsv), .rsv_dr(rsv_dr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regbank_sb #(.WIDTH(32), .AW(5), .ZERO_R0(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .sr1(sr1), .sr2(sr2),
    .rdData1(nb_rd1), .rdData2(nb_rd2), .busy1(nb_b1), .busy2(nb_b2),
    .write(write), .dr(dr), .wrData(wrData), .rsv(rsv), .rsv_dr(rsv_dr),
    .clr_req(clr_req), .clr_busy(nb_cb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: all expectations pushed in a cycle are checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if ({rdData1, rdData2, busy1, busy2, clr_busy} === {e.d1, e.d2, e.b1, e.b2, e.cb}) begin
        n_pass++;
        $display("check %s ok: d1=%h d2=%h b1=%b b2=%b cb=%b", e.name, rdData1, rdData2, busy1, busy2, clr_busy);
      end else begin
        $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b cb=%b, required d1=%h d2=%h b1=%b b2=%b cb=%b",
                 e.name, rdData1, rdData2, busy1, busy2, clr_busy, e.d1, e.d2, e.b1, e.b2, e.cb);
      end
      if (e.chk_nb) begin
        n_checks++;
        if (nb_rd1 === e.nb1) begin
          n_pass++;
          $display("check %s_nobypass ok: d1=%h", e.name, nb_rd1);
        end else begin
          $display("FAIL %s_nobypass: got d1=%h, required d1=%h", e.name, nb_rd1, e.nb1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] d1, input logic [31:0] d2,
                           input logic b1, input logic b2, input logic cb);
    exp_t e;
    e.name = name; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.cb = cb;
    e.chk_nb = 1'b0; e.nb1 = '0;
    sb_q.push_back(e);
  endtask

  task automatic expect_nb(input string name, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] nb1);
    exp_t e;
    e.name = name; e.d1 = d1; e.d2 = d2; e.b1 = 1'b0; e.b2 = 1'b0; e.cb = 1'b0;
    e.chk_nb = 1'b1; e.nb1 = nb1;
    sb_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; sr1 = '0; sr2 = '0; write = 1'b0; dr = '0; wrData = '0;
    rsv = 1'b0; rsv_dr = '0; clr_req = 1'b0;

    // Reset state on every address.
    step();
    for (int i = 0; i < 32; i++) begin
      sr1 = 5'(i); sr2 = 5'(31 - i);
      expect_rd("reset_read", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
    end
    reset = 1'b1;
    step();

    // Write r5 and (dropped) r0.
    write = 1'b1; dr = 5'd5; wrData = 32'hDEADBEEF; step();
    dr = 5'd0; wrData = 32'h12345678; step();
    write = 1'b0; sr1 = 5'd5; sr2 = 5'd0;
    expect_rd("wr_r5_r0", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Bypass on both ports; the BYPASS=0 instance still sees the old value.
    write = 1'b1; dr = 5'd7; wrData = 32'h1; step();
    wrData = 32'hA5A5A5A5; sr1 = 5'd7; sr2 = 5'd7;
    expect_nb("bypass", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1);
    step();
    write = 1'b0;
    expect_nb("after_bypass", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step();

    // Scoreboard.
    rsv = 1'b1; rsv_dr = 5'd9; sr1 = 5'd9; sr2 = 5'd5; step();
    rsv = 1'b0;
    expect_rd("rsv_r9", 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    step();
    write = 1'b1; dr = 5'd9; wrData = 32'h99;
    expect_rd("wr_r9_bypass", 32'h99, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();
    write = 1'b0;
    expect_rd("wr_r9_release", 32'h99, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();
    write = 1'b1; wrData = 32'h77; rsv = 1'b1; rsv_dr = 5'd9;
    expect_rd("wr_rsv_bypass", 32'h77, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();
    write = 1'b0; rsv = 1'b0;
    expect_rd("wr_rsv_r9", 32'h77, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    step();
    rsv = 1'b1; rsv_dr = 5'd0; sr1 = 5'd0; step();
    rsv = 1'b0;
    expect_rd("rsv_r0", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();

    // Asynchronous reset: outputs drop before any rising edge.
    sr1 = 5'd5; sr2 = 5'd9;
    expect_rd("pre_async", 32'hDEADBEEF, 32'h77, 1'b0, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    expect_rd("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();

    // Fill r1..r31, reserve r3, then sweep.
    for (int i = 1; i < 32; i++) begin
      write = 1'b1; dr = 5'(i); wrData = 32'h10000000 | 32'(i);
      step();
    end
    write = 1'b0;
    rsv = 1'b1; rsv_dr = 5'd3; step();
    rsv = 1'b0; sr1 = 5'd3; sr2 = 5'd31; clr_req = 1'b1;
    expect_rd("fill", 32'h10000003, 32'h1000001F, 1'b1, 1'b0, 1'b0);
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      // sr2 tracks the index about to be cleared, so it still holds data.
      sr2 = 5'(k);
      sr1 = (k == 2) ? 5'd4 : 5'd31;
      write = (k == 2); dr = 5'd4; wrData = 32'hFFFFFFFF;
      rsv = (k == 5); rsv_dr = 5'd31;
      clr_req = (k == 31);
      expect_rd("sweep",
                (k == 2) ? 32'h10000004 : 32'h1000001F,
                (k == 0) ? 32'h0 : (32'h10000000 | 32'(k)),
                1'b0, (k == 3), 1'b1);
      step();
    end
    write = 1'b0; rsv = 1'b0; clr_req = 1'b0;
    write = 1'b1; dr = 5'd4; wrData = 32'hCAFE; sr1 = 5'd31; sr2 = 5'd3;
    expect_rd("sweep_done", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sr1 = 5'(i); sr2 = 5'((i + 16) % 32);
      expect_rd("post_sweep",
                (i == 4) ? 32'hCAFE : 32'h0,
                (i == 20) ? 32'hCAFE : 32'h0,
                1'b0, 1'b0, 1'b0);
      step();
    end

    // Reset in the middle of a sweep, then a complete new sweep.
    write = 1'b1; dr = 5'd20; wrData = 32'hBEEF; rsv = 1'b1; rsv_dr = 5'd21; step();
    write = 1'b0; rsv = 1'b0; sr1 = 5'd20; sr2 = 5'd21; clr_req = 1'b1;
    expect_rd("pre_sweep2", 32'hBEEF, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_rd("sweep2", 32'hBEEF, 32'h0, 1'b0, 1'b1, 1'b1);
      step();
    end
    reset = 1'b0;
    expect_rd("reset_mid_sweep", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1; clr_req = 1'b1;
    expect_rd("idle_after_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      expect_rd("sweep3", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
    end
    expect_rd("sweep3_done", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();

    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
